match_event_counter: RTL and testbench

- Downstream consumer of the 4-bit constant-equality comparator output Q.
- Synchronises the comparator's combinational match line and debounces it, so a match is accepted only after DEBOUNCE consecutive high cycles.
- Emits one pulse per accepted match and keeps a saturating match count.
- Raises a sticky alarm when the count reaches a programmable threshold. Result is consumed by status/interrupt logic.

---
 rtl/match_event_counter_pkg.sv | 23 ++
 rtl/match_event_counter_if.sv | 30 +++
 rtl/match_event_counter_sync_ff.sv | 28 ++
 rtl/match_event_counter.sv | 128 ++++++++++++
 tb/tb_match_event_counter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/match_event_counter_pkg.sv
// ============================================================================
// comparador_pkg : shared FSM state type, debounce limit, saturating increment
// Rev 1.0
// ============================================================================
`default_nettype none

package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2
    } match_state_t;

    localparam int DEBOUNCE_MAX = 15;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] cnt_max);
        return (cnt >= cnt_max) ? cnt : cnt + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/match_event_counter_if.sv
// ============================================================================
// match_event_counter_if : control/status bundle of the match event counter
// Rev 1.0
// ============================================================================
`default_nettype none

interface match_event_counter_if #(
    parameter int CNT_W = 8
);
    logic             q_in;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] threshold;
    logic             match_pulse;
    logic [CNT_W-1:0] count;
    logic             alarm;
    logic [1:0]       state_o;

    modport master (
        output q_in, en, clr, threshold,
        input  match_pulse, count, alarm, state_o
    );

    modport slave (
        input  q_in, en, clr, threshold,
        output match_pulse, count, alarm, state_o
    );
endinterface

`default_nettype wire

// File: rtl/match_event_counter_sync_ff.sv
// ============================================================================
// sync_ff : multi-flop synchroniser for one asynchronous input bit
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/match_event_counter.sv
// ============================================================================
// match_event_counter : debounces the comparator match line, counts accepted
// matches with saturation and raises a sticky threshold alarm.  Rev 1.0
// ============================================================================
`default_nettype none

module match_event_counter
    import comparador_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEBOUNCE    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    match_event_counter_if.slave  bus
);
    localparam int              c_STAB_W    = $clog2(DEBOUNCE_MAX + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(DEBOUNCE - 1);
    localparam logic [31:0]     c_CNT_MAX   = 32'({CNT_W{1'b1}});

    logic                w_q_s;
    match_state_t        r_state;
    match_state_t        w_state_nxt;
    logic [c_STAB_W-1:0] r_stab;
    logic [c_STAB_W-1:0] w_stab_nxt;
    logic                w_accept;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                r_pulse;
    logic                r_alarm;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.q_in),
        .o_q   (w_q_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_stab  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stab  <= w_stab_nxt;
        end
    end

    // Every path not explicitly held falls back to IDLE, which also covers
    // en=0 and the unused encoding 3.
    always_comb begin
        w_state_nxt = IDLE;
        w_stab_nxt  = '0;
        if (bus.en) begin
            case (r_state)
                IDLE: begin
                    if (w_q_s) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = HELD;
                        end else begin
                            w_state_nxt = ARM;
                            w_stab_nxt  = c_STAB_W'(1);
                        end
                    end
                end
                ARM: begin
                    if (w_q_s) begin
                        if (r_stab == c_STAB_LAST) begin
                            w_state_nxt = HELD;
                        end else begin
                            w_state_nxt = ARM;
                            w_stab_nxt  = r_stab + c_STAB_W'(1);
                        end
                    end
                end
                HELD: begin
                    if (w_q_s) begin
                        w_state_nxt = HELD;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_accept = 1'b0;
        if (bus.en && w_q_s) begin
            if (r_state == IDLE && DEBOUNCE == 1) begin
                w_accept = 1'b1;
            end else if (r_state == ARM && r_stab == c_STAB_LAST) begin
                w_accept = 1'b1;
            end
        end
    end

    assign w_count_nxt = w_accept ? CNT_W'(sat_inc(32'(r_count), c_CNT_MAX)) : r_count;

    // clr wins over a coincident accept; the FSM keeps running so a held
    // match is not counted again once clr drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_pulse <= 1'b0;
            r_alarm <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_pulse <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_pulse <= w_accept;
            r_alarm <= r_alarm | ((bus.threshold != '0) && (w_count_nxt >= bus.threshold));
        end
    end

    assign bus.match_pulse = r_pulse;
    assign bus.count       = r_count;
    assign bus.alarm       = r_alarm;
    assign bus.state_o     = r_state;
endmodule

`default_nettype wire

// File: tb/tb_match_event_counter.sv
// ============================================================================
// tb_match_event_counter : directed vector table plus multi-cycle sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_match_event_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    match_event_counter_if #(.CNT_W(8)) ifa ();
    match_event_counter_if #(.CNT_W(4)) ifb ();

    match_event_counter #(.CNT_W(8), .DEBOUNCE(3), .SYNC_STAGES(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    match_event_counter #(.CNT_W(4), .DEBOUNCE(3), .SYNC_STAGES(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    typedef struct {
        logic       q_in;
        logic       en;
        logic       clr;
        logic [7:0] thr;
        logic       exp_pulse;
        logic [7:0] exp_count;
        logic       exp_alarm;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic q, input logic e, input logic c, input logic [7:0] t,
                                input logic p, input logic [7:0] cnt, input logic a, input logic [1:0] s);
        vec_t v;
        v.q_in = q; v.en = e; v.clr = c; v.thr = t;
        v.exp_pulse = p; v.exp_count = cnt; v.exp_alarm = a; v.exp_state = s;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int sel, input logic v);
        if (sel == 0) ifa.q_in = v;
        else          ifb.q_in = v;
    endtask

    function automatic int get_pulse(input int sel);
        return (sel == 0) ? int'(ifa.match_pulse) : int'(ifb.match_pulse);
    endfunction

    function automatic int get_count(input int sel);
        return (sel == 0) ? int'(ifa.count) : int'(ifb.count);
    endfunction

    function automatic int get_alarm(input int sel);
        return (sel == 0) ? int'(ifa.alarm) : int'(ifb.alarm);
    endfunction

    function automatic int get_state(input int sel);
        return (sel == 0) ? int'(ifa.state_o) : int'(ifb.state_o);
    endfunction

    // One clean match: q_in high for hi cycles then low for lo cycles.
    task automatic do_match(input int sel, input int hi, input int lo, input int exp_cnt, input int exp_al);
        int pulses = 0;
        int cnt_at = -1;
        int al_at  = -1;
        set_q(sel, 1'b1);
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) set_q(sel, 1'b0);
            tick();
            if (get_pulse(sel) == 1) begin
                pulses++;
                cnt_at = get_count(sel);
                al_at  = get_alarm(sel);
            end
        end
        check("match_pulse_count", pulses, 1);
        check("count_at_pulse", cnt_at, exp_cnt);
        check("alarm_at_pulse", al_at, exp_al);
    endtask

    initial begin
        int pulses;
        logic [1:0] glitch_st [7];

        // Reset latency sequence: q_in held high through reset release.
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, 1, 0, 0, (i == 4), (i >= 4) ? 8'd1 : 8'd0, 0,
                              (i < 2) ? 2'd0 : (i < 4) ? 2'd1 : 2'd2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        // Short high runs never reach HELD.
        glitch_st = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 7; j++)
                vecs.push_back(mk((j < 2), 1, 0, 0, 0, 0, 0, glitch_st[j]));

        rst_n = 1'b0;
        ifa.q_in = 1'b1; ifa.en = 1'b1; ifa.clr = 1'b0; ifa.threshold = 8'd0;
        ifb.q_in = 1'b0; ifb.en = 1'b1; ifb.clr = 1'b0; ifb.threshold = 4'd0;
        tick();
        tick();
        check("rst_pulse", int'(ifa.match_pulse), 0);
        check("rst_count", int'(ifa.count), 0);
        check("rst_alarm", int'(ifa.alarm), 0);
        check("rst_state", int'(ifa.state_o), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ifa.q_in = vecs[i].q_in;
            ifa.en = vecs[i].en;
            ifa.clr = vecs[i].clr;
            ifa.threshold = vecs[i].thr;
            tick();
            check($sformatf("vec%0d_pulse", i), int'(ifa.match_pulse), int'(vecs[i].exp_pulse));
            check($sformatf("vec%0d_count", i), int'(ifa.count), int'(vecs[i].exp_count));
            check($sformatf("vec%0d_alarm", i), int'(ifa.alarm), int'(vecs[i].exp_alarm));
            check($sformatf("vec%0d_state", i), int'(ifa.state_o), int'(vecs[i].exp_state));
        end

        // Threshold alarm rises with the third count and stays.
        ifa.threshold = 8'd3;
        do_match(0, 6, 4, 1, 0);
        do_match(0, 6, 4, 2, 0);
        do_match(0, 6, 4, 3, 1);
        check("alarm_sticky", int'(ifa.alarm), 1);
        check("count_after_thr", int'(ifa.count), 3);

        // clr on the accepting edge.
        ifa.threshold = 8'd0;
        ifa.clr = 1'b1; tick(); ifa.clr = 1'b0;
        check("clr_alarm", int'(ifa.alarm), 0);
        for (int m = 1; m <= 5; m++) do_match(0, 6, 4, m, 0);
        ifa.q_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("pre_accept_state", int'(ifa.state_o), 1);
        ifa.clr = 1'b1;
        tick();
        ifa.clr = 1'b0;
        check("clr_accept_pulse", int'(ifa.match_pulse), 0);
        check("clr_accept_count", int'(ifa.count), 0);
        check("clr_accept_state", int'(ifa.state_o), 2);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(ifa.match_pulse);
        end
        check("held_no_recount_pulse", pulses, 0);
        check("held_no_recount_count", int'(ifa.count), 0);
        ifa.q_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        do_match(0, 6, 4, 1, 0);

        // Saturation on the 4-bit instance.
        for (int m = 1; m <= 17; m++) do_match(1, 6, 4, (m > 15) ? 15 : m, 0);
        check("sat_count", int'(ifb.count), 15);
        ifb.q_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("b_mid_arm_state", int'(ifb.state_o), 1);
        ifb.en = 1'b0;
        tick();
        check("en_off_state", int'(ifb.state_o), 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(ifb.match_pulse) + ((ifb.state_o != 2'd0) ? 1 : 0);
        end
        check("en_off_quiet", pulses, 0);
        check("en_off_count", int'(ifb.count), 15);
        ifb.q_in = 1'b0;
        ifb.en = 1'b1;

        // Asynchronous reset while HELD with count=7 and alarm set.
        ifa.clr = 1'b1; tick(); ifa.clr = 1'b0;
        ifa.threshold = 8'd7;
        for (int m = 1; m <= 6; m++) do_match(0, 6, 4, m, 0);
        ifa.q_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("seventh_pulse", int'(ifa.match_pulse), 1);
        check("seventh_count", int'(ifa.count), 7);
        check("seventh_alarm", int'(ifa.alarm), 1);
        tick();
        check("held_state", int'(ifa.state_o), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(ifa.count), 0);
        check("async_rst_alarm", int'(ifa.alarm), 0);
        check("async_rst_state", int'(ifa.state_o), 0);
        check("async_rst_pulse", int'(ifa.match_pulse), 0);
        #2 rst_n = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("post_rst_pulse_edge5", int'(ifa.match_pulse), 1);
            pulses += int'(ifa.match_pulse);
        end
        check("post_rst_pulses", pulses, 1);
        check("post_rst_count", int'(ifa.count), 1);
        check("post_rst_alarm", int'(ifa.alarm), 0);
        check("post_rst_state", int'(ifa.state_o), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
